// File: rtl/spectrum_frame_ctrl.sv
// spectrum_frame_ctrl: frame sequencer for the spectrum analyzer datapath.
// Captures 2**N_LOG2 ADC samples and launches the FFT. When the FFT is done it
// streams the lower half of the spectrum to the display over valid/ready.
// Optional build macro: SA_AUTO_RESTART_EN
//   defined   -> after the last bin the FSM re-enters CAPTURE (continuous run)
//   undefined -> single-shot, returns to IDLE after each frame
module spectrum_frame_ctrl #(
   parameter int N_LOG2  = 8,
   parameter int TIMEOUT = 4096
) (
   input  logic              Clk,
   input  logic              reset,
   input  logic              start,
   input  logic              abort,
   input  logic              sample_valid,
   output logic              cap_we,
   output logic [N_LOG2-1:0] cap_addr,
   output logic              fft_start,
   input  logic              fft_done,
   output logic [N_LOG2-2:0] rd_addr,
   output logic              rd_valid,
   input  logic              rd_ready,
   output logic              busy,
   output logic              frame_done,
   output logic              fft_err,
   output logic [1:0]        state
);

   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [N_LOG2-1:0] CAP_LAST = '1;
   localparam logic [N_LOG2-2:0] RD_LAST  = '1;
   localparam logic [TW-1:0]     TMO_LAST = TW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_CAPTURE = 2'd1,
      S_COMPUTE = 2'd2,
      S_OUTPUT  = 2'd3
   } state_t;

   state_t              r_state;
   logic [N_LOG2-1:0]   r_cap_addr;
   logic [N_LOG2-2:0]   r_rd_addr;
   logic [TW-1:0]       r_tmo;
   logic                r_fft_start;
   logic                r_frame_done;
   logic                r_fft_err;

   state_t              w_state_nxt;
   logic [N_LOG2-1:0]   w_cap_addr_nxt;
   logic [N_LOG2-2:0]   w_rd_addr_nxt;
   logic [TW-1:0]       w_tmo_nxt;
   logic                w_fft_start_nxt;
   logic                w_frame_done_nxt;
   logic                w_fft_err_nxt;
   logic                w_cap_we;
   logic                w_rd_valid;

   // State register.
   always_ff @(posedge Clk or negedge reset) begin
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   // Next-state logic plus next values for counters and registered pulses.
   // r_fft_start doubles as the "first COMPUTE cycle" marker, in which a
   // stale fft_done from a previous run must be ignored.
   always_comb begin
      w_state_nxt      = r_state;
      w_cap_addr_nxt   = r_cap_addr;
      w_rd_addr_nxt    = r_rd_addr;
      w_tmo_nxt        = '0;
      w_fft_start_nxt  = 1'b0;
      w_frame_done_nxt = 1'b0;
      w_fft_err_nxt    = r_fft_err;
      w_cap_we         = 1'b0;
      w_rd_valid       = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_cap_addr_nxt = '0;
            w_rd_addr_nxt  = '0;
            if (start && !abort) begin
               w_state_nxt   = S_CAPTURE;
               w_fft_err_nxt = 1'b0;
            end
         end
         S_CAPTURE: begin
            w_cap_we = sample_valid;
            if (abort) begin
               w_state_nxt    = S_IDLE;
               w_cap_addr_nxt = '0;
            end else if (sample_valid) begin
               w_cap_addr_nxt = r_cap_addr + 1'b1;
               if (r_cap_addr == CAP_LAST) begin
                  w_state_nxt     = S_COMPUTE;
                  w_fft_start_nxt = 1'b1;
               end
            end
         end
         S_COMPUTE: begin
            if (abort) begin
               w_state_nxt = S_IDLE;
            end else if (fft_done && !r_fft_start) begin
               w_state_nxt   = S_OUTPUT;
               w_rd_addr_nxt = '0;
            end else if (r_tmo == TMO_LAST) begin
               w_state_nxt   = S_IDLE;
               w_fft_err_nxt = 1'b1;
            end else begin
               w_tmo_nxt = r_tmo + 1'b1;
            end
         end
         S_OUTPUT: begin
            w_rd_valid = 1'b1;
            if (abort) begin
               w_state_nxt   = S_IDLE;
               w_rd_addr_nxt = '0;
            end else if (rd_ready) begin
               w_rd_addr_nxt = r_rd_addr + 1'b1;
               if (r_rd_addr == RD_LAST) begin
                  w_frame_done_nxt = 1'b1;
                  w_cap_addr_nxt   = '0;
`ifdef SA_AUTO_RESTART_EN
                  w_state_nxt      = S_CAPTURE;
`else
                  w_state_nxt      = S_IDLE;
`endif
               end
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Address counters, timeout counter, registered pulses and sticky error.
   always_ff @(posedge Clk or negedge reset) begin
      if (!reset) begin
         r_cap_addr   <= '0;
         r_rd_addr    <= '0;
         r_tmo        <= '0;
         r_fft_start  <= 1'b0;
         r_frame_done <= 1'b0;
         r_fft_err    <= 1'b0;
      end else begin
         r_cap_addr   <= w_cap_addr_nxt;
         r_rd_addr    <= w_rd_addr_nxt;
         r_tmo        <= w_tmo_nxt;
         r_fft_start  <= w_fft_start_nxt;
         r_frame_done <= w_frame_done_nxt;
         r_fft_err    <= w_fft_err_nxt;
      end
   end

   assign cap_we     = w_cap_we;
   assign cap_addr   = r_cap_addr;
   assign fft_start  = r_fft_start;
   assign rd_addr    = r_rd_addr;
   assign rd_valid   = w_rd_valid;
   assign busy       = (r_state != S_IDLE);
   assign frame_done = r_frame_done;
   assign fft_err    = r_fft_err;
   assign state      = r_state;

endmodule

// File: tb/tb_spectrum_frame_ctrl.sv
// Directed bench for spectrum_frame_ctrl. u_dut uses the default TIMEOUT;
// u_tmo shares every input but uses TIMEOUT=16 for the timeout scenario.
module tb_spectrum_frame_ctrl;
   localparam int NS = 256;
   localparam int NB = 128;
`ifdef SA_AUTO_RESTART_EN
   localparam int AUTO = 1;
`else
   localparam int AUTO = 0;
`endif

   logic Clk = 1'b0;
   logic reset = 1'b0;
   logic start = 1'b0, abort = 1'b0, sample_valid = 1'b0, fft_done = 1'b0, rd_ready = 1'b0;

   logic       cap_we, fft_start, rd_valid, busy, frame_done, fft_err;
   logic [7:0] cap_addr;
   logic [6:0] rd_addr;
   logic [1:0] state;

   logic       t_cap_we, t_fft_start, t_rd_valid, t_busy, t_frame_done, t_fft_err;
   logic [7:0] t_cap_addr;
   logic [6:0] t_rd_addr;
   logic [1:0] t_state;

   int n_vec = 0;
   int n_fail = 0;

   always #5 Clk = ~Clk;

   spectrum_frame_ctrl #(.N_LOG2(8), .TIMEOUT(4096)) u_dut (
      .Clk(Clk), .reset(reset), .start(start), .abort(abort),
      .sample_valid(sample_valid), .cap_we(cap_we), .cap_addr(cap_addr),
      .fft_start(fft_start), .fft_done(fft_done), .rd_addr(rd_addr),
      .rd_valid(rd_valid), .rd_ready(rd_ready), .busy(busy),
      .frame_done(frame_done), .fft_err(fft_err), .state(state)
   );

   spectrum_frame_ctrl #(.N_LOG2(8), .TIMEOUT(16)) u_tmo (
      .Clk(Clk), .reset(reset), .start(start), .abort(abort),
      .sample_valid(sample_valid), .cap_we(t_cap_we), .cap_addr(t_cap_addr),
      .fft_start(t_fft_start), .fft_done(fft_done), .rd_addr(t_rd_addr),
      .rd_valid(t_rd_valid), .rd_ready(rd_ready), .busy(t_busy),
      .frame_done(t_frame_done), .fft_err(t_fft_err), .state(t_state)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
      n_vec++;
      assert (obs === req) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, req);
      end
   endtask

   // Inputs change 1 time unit after the rising edge; outputs are checked on the falling edge.
   task automatic edge_t();
      @(posedge Clk);
      #1;
   endtask

   task automatic mid();
      @(negedge Clk);
   endtask

   task automatic do_reset();
      reset = 1'b0; start = 1'b0; abort = 1'b0;
      sample_valid = 1'b0; fft_done = 1'b0; rd_ready = 1'b0;
      edge_t();
      edge_t();
      reset = 1'b1;
   endtask

   task automatic start_frame();
      start = 1'b1;
      mid();
      chk("busy_before_start_edge", busy, 0);
      edge_t();
      start = 1'b0;
   endtask

   task automatic capture(input bit alt);
      for (int k = 0; k < NS; k++) begin
         sample_valid = 1'b1;
         mid();
         if (k == 0) chk("capture_state", state, 1);
         chk("cap_addr", cap_addr, k);
         chk("cap_we", cap_we, 1);
         edge_t();
         if (alt && k != NS-1) begin
            sample_valid = 1'b0;
            mid();
            chk("cap_we_gap", cap_we, 0);
            chk("fft_start_in_capture", fft_start, 0);
            edge_t();
         end
      end
      sample_valid = 1'b0;
   endtask

   // Leaves u_dut in OUTPUT: fft_done in the second COMPUTE cycle.
   task automatic enter_output();
      mid();
      edge_t();
      fft_done = 1'b1;
      mid();
      edge_t();
      fft_done = 1'b0;
   endtask

   initial begin
      int exp_addr;
      int hs;
      int cyc;

      // ---- reset values ----
      sample_valid = 1'b1;
      #12;
      chk("rst_state", state, 0);
      chk("rst_busy", busy, 0);
      chk("rst_cap_addr", cap_addr, 0);
      chk("rst_rd_addr", rd_addr, 0);
      chk("rst_cap_we", cap_we, 0);
      chk("rst_rd_valid", rd_valid, 0);
      chk("rst_fft_start", fft_start, 0);
      chk("rst_frame_done", frame_done, 0);
      chk("rst_fft_err", fft_err, 0);
      do_reset();

      // ---- full frame: alternate-cycle capture, fft_done 40 cycles after fft_start ----
      start_frame();
      capture(1'b1);
      fft_done = 1'b1;             // must be ignored in the first COMPUTE cycle
      mid();
      chk("fft_start_rise", fft_start, 1);
      chk("compute_state", state, 2);
      chk("cap_addr_wrap", cap_addr, 0);
      edge_t();
      fft_done = 1'b0;
      for (int c = 1; c < 40; c++) begin
         mid();
         chk("fft_start_single", fft_start, 0);
         chk("compute_hold", state, 2);
         edge_t();
      end
      fft_done = 1'b1;
      rd_ready = 1'b1;
      mid();
      chk("rd_valid_before_output", rd_valid, 0);
      edge_t();
      fft_done = 1'b0;
      for (int b = 0; b < NB; b++) begin
         mid();
         chk("rd_addr_stream", rd_addr, b);
         chk("rd_valid_stream", rd_valid, 1);
         chk("frame_done_early", frame_done, 0);
         edge_t();
      end
      mid();
      chk("frame_done_pulse", frame_done, 1);
      chk("busy_after_frame", busy, AUTO);
      chk("state_after_frame", state, AUTO);
      chk("cap_addr_after_frame", cap_addr, 0);
      chk("fft_err_clean", fft_err, 0);
      edge_t();
      rd_ready = 1'b0;
      mid();
      chk("frame_done_once", frame_done, 0);
      edge_t();

      // ---- rd_ready pattern 1,0,0,1 ----
      do_reset();
      start_frame();
      capture(1'b0);
      enter_output();
      exp_addr = 0;
      hs = 0;
      cyc = 0;
      for (int i = 0; i < 600; i++) begin
         rd_ready = (i % 4 == 0) || (i % 4 == 3);
         mid();
         if (state != 2'd3) break;
         chk("rd_addr_backpressure", rd_addr, exp_addr);
         if (rd_ready) begin
            hs++;
            exp_addr++;
         end
         cyc++;
         edge_t();
      end
      chk("bp_finished_in_budget", (cyc < 600), 1);
      chk("bp_handshakes", hs, NB);
      chk("bp_frame_done", frame_done, 1);
      edge_t();
      rd_ready = 1'b0;

      // ---- asynchronous reset mid-OUTPUT at rd_addr=17 ----
      do_reset();
      start_frame();
      capture(1'b0);
      enter_output();
      rd_ready = 1'b1;
      for (int i = 0; i < 17; i++) begin
         mid();
         edge_t();
      end
      mid();
      chk("pre_reset_rd_addr", rd_addr, 17);
      reset = 1'b0;
      #1;
      chk("async_state", state, 0);
      chk("async_rd_addr", rd_addr, 0);
      chk("async_rd_valid", rd_valid, 0);
      chk("async_busy", busy, 0);
      chk("async_frame_done", frame_done, 0);
      edge_t();
      rd_ready = 1'b0;
      reset = 1'b1;

      // ---- FFT timeout on u_tmo (TIMEOUT=16) ----
      do_reset();
      start_frame();
      capture(1'b0);
      mid();
      chk("tmo_fft_start", t_fft_start, 1);
      edge_t();
      for (int c = 1; c < 16; c++) begin
         mid();
         chk("tmo_wait_state", t_state, 2);
         chk("tmo_wait_err", t_fft_err, 0);
         edge_t();
      end
      mid();
      chk("tmo_state_idle", t_state, 0);
      chk("tmo_err_set", t_fft_err, 1);
      chk("tmo_no_frame_done", t_frame_done, 0);
      edge_t();
      start = 1'b1;
      mid();
      chk("tmo_err_sticky", t_fft_err, 1);
      edge_t();
      start = 1'b0;
      mid();
      chk("tmo_err_cleared", t_fft_err, 0);
      chk("tmo_restart_capture", t_state, 1);
      chk("start_ignored_busy", state, 2);
      edge_t();
      abort = 1'b1;
      mid();
      edge_t();
      abort = 1'b0;
      mid();
      chk("abort_compute", state, 0);
      chk("abort_capture_tmo", t_state, 0);
      edge_t();

      // ---- abort in CAPTURE at cap_addr=100, start ignored mid-capture ----
      do_reset();
      start_frame();
      for (int k = 0; k <= 100; k++) begin
         sample_valid = 1'b1;
         start = (k == 50);
         abort = (k == 100);
         mid();
         chk("abort_cap_addr", cap_addr, k);
         if (k == 51) chk("start_ignored_capture", state, 1);
         edge_t();
      end
      abort = 1'b0;
      start = 1'b0;
      sample_valid = 1'b0;
      mid();
      chk("abort_to_idle", state, 0);
      chk("abort_cap_clear", cap_addr, 0);
      chk("abort_no_fft_start", fft_start, 0);
      edge_t();
      mid();
      chk("abort_no_frame_done", frame_done, 0);
      edge_t();

      // ---- start and abort together: abort wins ----
      start = 1'b1;
      abort = 1'b1;
      mid();
      edge_t();
      start = 1'b0;
      abort = 1'b0;
      mid();
      chk("start_abort_idle", state, 0);
      edge_t();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule

// File: doc/spectrum_frame_ctrl.md
# spectrum_frame_ctrl

Frame sequencer for the spectrum analyzer datapath. On a `start` pulse it captures `2**N_LOG2` ADC samples into the sample buffer and launches the FFT core. When the FFT finishes, it streams the lower half of the spectrum (the bins the display uses) to the display writer over a valid/ready handshake. It sits between the top-level control inputs (`start`, `reset`) and the capture RAM, FFT core and display path.

## Interface
- `N_LOG2`, 8, log2 of frame length in samples (frame = 256)
- `TIMEOUT`, 4096, maximum cycles to wait for `fft_done` before declaring an error
- `Clk` in 1, system clock, rising edge
- `reset` in 1, asynchronous, active-low reset
- `start` in 1, one-cycle request to acquire and process one frame
- `abort` in 1, cancels the current frame
- `sample_valid` in 1, ADC sample strobe
- `cap_we` out 1, capture RAM write enable
- `cap_addr` out N_LOG2, capture RAM write address
- `fft_start` out 1, one-cycle FFT launch pulse
- `fft_done` in 1, FFT completion pulse/level
- `rd_addr` out N_LOG2-1, spectrum bin index presented to display
- `rd_valid` out 1, bin index valid
- `rd_ready` in 1, display accepts current bin
- `busy` out 1, high in any state other than IDLE
- `frame_done` out 1, one-cycle pulse after the last bin is accepted
- `fft_err` out 1, sticky timeout flag
- `state` out 2, IDLE=0, CAPTURE=1, COMPUTE=2, OUTPUT=3

## Operation
- Reset (`reset`=0) values: state IDLE; `cap_addr`, `rd_addr` and the timeout counter are 0; all single-bit outputs are 0, including `fft_err`.
- IDLE: if `start`=1 and `abort`=0, go to CAPTURE. `cap_addr` is cleared to 0.
- CAPTURE: `cap_we` = `sample_valid` (combinational, gated by state). `cap_addr` increments after each write. A write at address N-1 moves the FSM to COMPUTE, and `cap_addr` wraps to 0.
- COMPUTE: `fft_start` is registered and is 1 only in the first COMPUTE cycle. `fft_done` is ignored in that cycle. On a later `fft_done`=1 the FSM goes to OUTPUT with `rd_addr` = 0. If the timeout counter reaches TIMEOUT-1 first, `fft_err` is set and the FSM goes to IDLE without pulsing `frame_done`.
- OUTPUT: `rd_valid` = 1. `rd_addr` advances when `rd_valid` and `rd_ready` are both 1. The handshake at `rd_addr` = 2**(N_LOG2-1)-1 ends the frame: `frame_done` pulses in the next cycle and the FSM goes to IDLE.
- `start` is ignored while `busy`=1.
- `abort`=1 in any non-IDLE state returns the FSM to IDLE on the next edge, clears the counters and does not pulse `frame_done`. If `start` and `abort` are both 1, `abort` wins.
- `fft_err` clears only on reset or on an accepted `start`.

## Timing
- From `start` to CAPTURE is 1 cycle. `busy` rises on the edge after `start`.
- The write of sample k occurs in the cycle where `sample_valid` is high and `cap_addr` = k.
- From the final capture write to `fft_start` is 1 cycle.
- From `fft_done` to `rd_valid` is 1 cycle.
- With `rd_ready` held high, one bin is transferred per cycle. `rd_addr` is stable while `rd_ready`=0.
- `frame_done` and `busy` falling occur on the same edge.
- Asserting `reset` at any point forces the reset values immediately (asynchronous).

## Configuration
- `SA_AUTO_RESTART_EN` defined: after the final OUTPUT handshake the FSM goes to CAPTURE instead of IDLE. `frame_done` still pulses, `busy` stays 1 and `cap_addr` restarts at 0. Capture continues frame after frame until `abort` or `reset`.
- `SA_AUTO_RESTART_EN` undefined: single-shot behaviour as described in Operation.

## Test plan
- Reset mid-OUTPUT with `rd_addr`=17 → all outputs go to 0 and state=0 asynchronously, before the next `Clk` edge.
- `start`, then 256 `sample_valid` strobes on alternate cycles → `cap_we` is seen 256 times at addresses 0..255. `fft_start` is high for exactly 1 cycle, 1 cycle after the write to address 255.
- `fft_done` 40 cycles after `fft_start`, `rd_ready` held high → `rd_addr` runs 0..127 on consecutive cycles. `frame_done` pulses once, 129 cycles after `fft_done`, and `busy` falls on the same edge.
- `rd_ready` toggling 1,0,0,1 → `rd_addr` advances only on cycles where `rd_ready`=1. A total of 128 handshakes occurs, with no bins skipped or repeated.
- `fft_done` never arrives with TIMEOUT=16 → `fft_err`=1 and state=IDLE 16 cycles after `fft_start`, and `frame_done` stays 0. The next `start` clears `fft_err`.
- `abort` in CAPTURE at `cap_addr`=100 → state=IDLE on the next edge and no `fft_start`. A `start` asserted during CAPTURE is ignored. With `SA_AUTO_RESTART_EN` defined, the FSM re-enters CAPTURE after `frame_done`.
